shift_unit_iter: RTL and testbench
==================================

Name: shift_unit_iter

Overview:
- Parametrised, multi-cycle shifter that replaces the fixed combinational shift-left-by-one used in branch-offset and immediate paths.
- Supports variable shift amount and four modes: SLL, SRL, SRA, ROL.
- Shifts iteratively, up to STEP bits per cycle, so area and timing scale with STEP.
- Uses a valid/ready handshake on both sides; it sits beside the ALU as a shared shift resource for the multi-cycle CPU generation.

Parameters:
- WIDTH, 64, data width; power of 2, at least 2.
- STEP, 1, maximum bits shifted per cycle; power of 2, 1 to WIDTH.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- data_i  input  WIDTH  operand.
- shamt_i  input  SHW  shift amount, 0 to WIDTH-1.
- mode_i  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts result.
- data_o  output  WIDTH  result.

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values:
  - state=IDLE, ready_o=1, valid_o=0, data_o=0.
  - Internal remaining count = 0, mode register = 0.
  - Reset has priority over every other event, including reset mid-SHIFT or mid-DONE. Any in-flight operation is discarded with no result.
- States:
  - IDLE: ready_o=1, valid_o=0.
  - SHIFT: ready_o=0, valid_o=0.
  - DONE: ready_o=0, valid_o=1.
- IDLE:
  - On the edge with valid_i&&ready_o, capture data_i into the work register, and shamt_i and mode_i into internal registers.
  - If shamt_i==0, go to DONE; otherwise go to SHIFT.
  - With valid_i low, stay in IDLE; registers are unchanged.
- SHIFT:
  - Each edge, let n = min(remaining, STEP).
  - Apply the n-bit operation of the captured mode to the work register, then remaining -= n.
  - When remaining reaches 0 on this edge, go to DONE.
- DONE:
  - data_o holds the result stable while valid_o=1.
  - On an edge with ready_i=1, go to IDLE; data_o keeps its last value.
- Latency:
  - Acceptance edge T; k = ceil(shamt/STEP).
  - valid_o is high in the cycle after edge T+k (k=0: the cycle after T).
  - Throughput is one request per k+2 cycles minimum.
  - There is no accept-while-DONE overlap.
- Handshake:
  - valid_i is ignored unless ready_o=1.
  - data_i, shamt_i and mode_i are sampled only on the acceptance edge; later changes have no effect.
- Mode semantics, per step of n bits:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with the original sign bit (MSB of the work register, which is invariant under SRA).
  - ROL: bits leaving the MSB re-enter at the LSB.
  - The total result equals the single-shot operation by shamt (modulo WIDTH for ROL).
- data_o:
  - Driven from the work register.
  - Defined only while valid_o=1.
  - Intermediate values during SHIFT are visible but carry no meaning.
- Boundaries:
  - shamt=WIDTH-1 is supported with all modes.
  - STEP=WIDTH means every non-zero shift finishes in one SHIFT cycle.
  - ready_i held low indefinitely keeps the unit in DONE with output stable.
  - ready_i high outside DONE has no effect.

Decomposition:
- Shared header of defines: mode encodings SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_ROL=2'b11; state encodings IDLE/SHIFT/DONE.
- One natural combinational sub-module, shift_step_comb (WIDTH, STEP): inputs are the work value, n (0 to STEP) and mode; output is the shifted value.
- The FSM, counters and handshake stay in shift_unit_iter.

Test Plan:
- Legacy equivalence (WIDTH=64, STEP=1): data_i=64'h1, shamt=1, SLL → valid_o one cycle after acceptance, data_o=64'h2; random data_i, shamt=1, SLL → data_o == data_i<<1.
- SRA (STEP=1): data_i=64'h8000_0000_0000_0000, shamt=4 → valid_o after 4 cycles, data_o=64'hF800_0000_0000_0000. SRL with the same operand and shamt=63, STEP=8 → data_o=64'h1 after 8 cycles.
- ROL with STEP=4: data_i=64'h8000_0000_0000_0001, shamt=1 → 64'h3 after 1 cycle; data_i=64'h1, shamt=9 → 64'h200 after 3 cycles.
- shamt=0, any mode: data_i=64'hDEAD_BEEF_0123_4567 → valid_o in the cycle after acceptance, data_o unchanged.
- Backpressure: hold ready_i=0 for 5 cycles in DONE → data_o and valid_o stable, ready_o=0, toggling valid_i/data_i ignored. Raise ready_i → IDLE, ready_o=1 next cycle.
- Reset mid-SHIFT (shamt=40, STEP=1, rst_i at cycle 10) → next cycle valid_o=0, data_o=0, ready_o=1. A new request then completes correctly.

Source files
------------

// File: rtl/shift_unit_iter_pkg.sv
// rtl/shift_unit_iter_pkg.sv - shared mode and state encodings for the iterative shifter
package shift_unit_iter_pkg;

    // Operation encodings presented on mode_i
    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b10;
    localparam logic [1:0] SHIFT_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_unit_iter_step.sv
// rtl/shift_unit_iter_step.sv - one iteration of the shifter: shift by n (0..STEP) bits
module shift_step_comb
    import shift_unit_iter_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int STEP  = 1,
    localparam int NW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic [NW-1:0]    i_n,
    input  logic [1:0]       i_mode,
    output logic [WIDTH-1:0] o_value
);

    // The shift amount is only NW bits wide, so the mux depth grows with STEP, not WIDTH.
    // SRA keeps replicating the MSB, which never changes under SRA, so per-step
    // sign fill equals the original sign bit.
    always_comb begin
        o_value = i_value;
        case (i_mode)
            SHIFT_SLL: o_value = i_value << i_n;
            SHIFT_SRL: o_value = i_value >> i_n;
            SHIFT_SRA: o_value = $signed(i_value) >>> i_n;
            SHIFT_ROL: o_value = (i_value << i_n) | (i_value >> (WIDTH - int'(i_n)));
            default:   o_value = i_value;
        endcase
    end

endmodule

// File: rtl/shift_unit_iter.sv
// rtl/shift_unit_iter.sv - multi-cycle shifter (SLL/SRL/SRA/ROL) with valid/ready on both sides
module shift_unit_iter
    import shift_unit_iter_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int STEP  = 1,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic [SHW-1:0]   shamt_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    localparam int NW = $clog2(STEP + 1);
    // STEP may equal WIDTH, which does not fit in SHW bits, hence the extra bit
    localparam logic [SHW:0] STEP_X = (SHW + 1)'(STEP);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] w_step_value;
    logic [SHW-1:0]   r_remaining;
    logic [1:0]       r_mode;
    logic [NW-1:0]    w_n;
    logic             w_accept;
    logic             w_last;

    assign w_accept = valid_i && ready_o;
    // The final iteration is the one where what is left fits within STEP
    assign w_last   = ({1'b0, r_remaining} <= STEP_X);
    assign w_n      = w_last ? NW'(r_remaining) : NW'(STEP);
    assign data_o   = r_work;

    shift_step_comb #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_value (r_work),
        .i_n     (w_n),
        .i_mode  (r_mode),
        .o_value (w_step_value)
    );

    // State register; reset discards any in-flight operation
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        ready_o     = 1'b0;
        valid_o     = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_state_nxt = (shamt_i == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture on acceptance, then one partial shift per cycle while in SHIFT
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_work      <= '0;
            r_remaining <= '0;
            r_mode      <= '0;
        end else if (w_accept) begin
            r_work      <= data_i;
            r_remaining <= shamt_i;
            r_mode      <= mode_i;
        end else if (r_state == SHIFT) begin
            r_work      <= w_step_value;
            r_remaining <= r_remaining - SHW'(w_n);
        end
    end

endmodule

// File: tb/tb_shift_unit_iter.sv
// tb/tb_shift_unit_iter.sv - self-checking bench for shift_unit_iter at STEP 1, 4 and 8
module tb_shift_unit_iter;

    localparam int NU = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i [NU];
    logic        ready_o [NU];
    logic [63:0] data_i  [NU];
    logic [5:0]  shamt_i [NU];
    logic [1:0]  mode_i  [NU];
    logic        valid_o [NU];
    logic        ready_i [NU];
    logic [63:0] data_o  [NU];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NU; g++) begin : g_dut
        shift_unit_iter #(
            .WIDTH (64),
            .STEP  ((g == 0) ? 1 : ((g == 1) ? 4 : 8))
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .valid_i (valid_i[g]),
            .ready_o (ready_o[g]),
            .data_i  (data_i[g]),
            .shamt_i (shamt_i[g]),
            .mode_i  (mode_i[g]),
            .valid_o (valid_o[g]),
            .ready_i (ready_i[g]),
            .data_o  (data_o[g])
        );
    end

    function automatic int step_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 4 : 8);
    endfunction

    // Single-shot reference of each operation
    function automatic logic [63:0] golden(input logic [63:0] d, input logic [5:0] s,
                                           input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return 64'($signed(d) >>> s);
            default: return (s == 6'd0) ? d : ((d << s) | (d >> (7'd64 - {1'b0, s})));
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 idle, 1 busy for ceil(shamt/STEP) edges, 2 result held
    int          m_phase [NU];
    int          m_cnt   [NU];
    logic [63:0] m_res   [NU];

    always @(posedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (rst) begin
                m_phase[u] <= 0;
                m_cnt[u]   <= 0;
                m_res[u]   <= '0;
            end else begin
                case (m_phase[u])
                    0: if (valid_i[u]) begin
                        m_res[u]   <= golden(data_i[u], shamt_i[u], mode_i[u]);
                        m_cnt[u]   <= (int'(shamt_i[u]) + step_of(u) - 1) / step_of(u);
                        m_phase[u] <= (shamt_i[u] == 6'd0) ? 2 : 1;
                    end
                    1: begin
                        m_cnt[u] <= m_cnt[u] - 1;
                        if (m_cnt[u] == 1) m_phase[u] <= 2;
                    end
                    default: if (ready_i[u]) m_phase[u] <= 0;
                endcase
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            check($sformatf("u%0d ready_o", u), 64'(ready_o[u]), 64'(m_phase[u] == 0));
            check($sformatf("u%0d valid_o", u), 64'(valid_o[u]), 64'(m_phase[u] == 2));
            if (m_phase[u] != 1)
                check($sformatf("u%0d data_o", u), data_o[u], m_res[u]);
        end
    end

    // Issue one request on unit u and check result and latency (edges after acceptance)
    task automatic op(input int u, input logic [63:0] d, input logic [5:0] s,
                      input logic [1:0] m, input logic [63:0] exp, input int expk,
                      input string name);
        int n;
        valid_i[u] = 1'b1;
        data_i[u]  = d;
        shamt_i[u] = s;
        mode_i[u]  = m;
        ready_i[u] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid_i[u] = 1'b0;
        data_i[u]  = {$urandom, $urandom};
        shamt_i[u] = 6'($urandom);
        mode_i[u]  = 2'($urandom);
        n = 0;
        while (!valid_o[u] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(expk));
        check({name, " data"}, data_o[u], exp);
        ready_i[u] = 1'b1;
        @(negedge clk);
        ready_i[u] = 1'b0;
        check({name, " ready after"}, 64'(ready_o[u]), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        int n;
        rst = 1'b1;
        for (int u = 0; u < NU; u++) begin
            valid_i[u] = 1'b0;
            data_i[u]  = '0;
            shamt_i[u] = '0;
            mode_i[u]  = '0;
            ready_i[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            check("reset ready_o", 64'(ready_o[u]), 64'd1);
            check("reset valid_o", 64'(valid_o[u]), 64'd0);
            check("reset data_o", data_o[u], 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        op(0, 64'h1, 6'd1, 2'b00, 64'h2, 1, "sll1");
        rd = {$urandom, $urandom};
        op(0, rd, 6'd1, 2'b00, rd << 1, 1, "sll1 random");
        op(0, 64'h8000_0000_0000_0000, 6'd4, 2'b10, 64'hF800_0000_0000_0000, 4, "sra4");
        op(0, 64'h8000_0000_0000_0000, 6'd63, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 63, "sra63");
        op(0, 64'h1, 6'd63, 2'b11, 64'h8000_0000_0000_0000, 63, "rol63");
        op(2, 64'h8000_0000_0000_0000, 6'd63, 2'b01, 64'h1, 8, "srl63 step8");
        op(2, 64'h1, 6'd63, 2'b00, 64'h8000_0000_0000_0000, 8, "sll63 step8");
        op(1, 64'h8000_0000_0000_0001, 6'd1, 2'b11, 64'h3, 1, "rol1 step4");
        op(1, 64'h1, 6'd9, 2'b11, 64'h200, 3, "rol9 step4");
        op(1, 64'hF000_0000_0000_000F, 6'd6, 2'b10, 64'hFFC0_0000_0000_0000, 2, "sra6 step4");
        for (int m = 0; m < 4; m++) begin
            op(0, 64'hDEAD_BEEF_0123_4567, 6'd0, 2'(m), 64'hDEAD_BEEF_0123_4567, 0, "shamt0 step1");
            op(1, 64'hDEAD_BEEF_0123_4567, 6'd0, 2'(m), 64'hDEAD_BEEF_0123_4567, 0, "shamt0 step4");
        end

        // Backpressure: result held while ready_i low, new requests ignored
        valid_i[0] = 1'b1;
        data_i[0]  = 64'h0F;
        shamt_i[0] = 6'd4;
        mode_i[0]  = 2'b00;
        ready_i[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        valid_i[0] = 1'b0;
        n = 0;
        while (!valid_o[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp latency", 64'(n), 64'd4);
        for (int i = 0; i < 5; i++) begin
            valid_i[0] = 1'(i % 2 == 0);
            data_i[0]  = {$urandom, $urandom};
            shamt_i[0] = 6'd0;
            @(negedge clk);
            check("bp valid_o", 64'(valid_o[0]), 64'd1);
            check("bp ready_o", 64'(ready_o[0]), 64'd0);
            check("bp data_o", data_o[0], 64'hF0);
        end
        valid_i[0] = 1'b0;
        ready_i[0] = 1'b1;
        @(negedge clk);
        ready_i[0] = 1'b0;
        check("bp release ready_o", 64'(ready_o[0]), 64'd1);
        check("bp release valid_o", 64'(valid_o[0]), 64'd0);
        check("bp release data_o", data_o[0], 64'hF0);

        // Reset in the middle of a long shift
        valid_i[0] = 1'b1;
        data_i[0]  = 64'h3;
        shamt_i[0] = 6'd40;
        mode_i[0]  = 2'b00;
        @(posedge clk);
        @(negedge clk);
        valid_i[0] = 1'b0;
        repeat (9) @(negedge clk);
        check("mid-shift valid_o", 64'(valid_o[0]), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post-reset valid_o", 64'(valid_o[0]), 64'd0);
        check("post-reset data_o", data_o[0], 64'd0);
        check("post-reset ready_o", 64'(ready_o[0]), 64'd1);
        op(0, 64'h3, 6'd40, 2'b00, 64'h300_0000_0000, 40, "sll40 after reset");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
